// File: rtl/relprime_top_level_if.sv
// rtl/relprime_top_level_if.sv - operand/result bundle for the relprime engine
//   register_value : n, the operand whose relative prime is sought
//   decimal_two    : initial candidate m (constant 2)
//   decimal_one    : candidate increment and gcd==1 comparison value
//   start          : level; operands (re)load while high, search runs once low
//   out            : result m, valid while done is high (0 means none found)
//   done           : result registered; held until the next start or RST
interface relprime_top_level_if #(
    parameter int W = 16
);
    logic [W-1:0] register_value;
    logic [W-1:0] decimal_two;
    logic [W-1:0] decimal_one;
    logic         start;
    logic [W-1:0] out;
    logic         done;

    modport master (
        output register_value,
        output decimal_two,
        output decimal_one,
        output start,
        input  out,
        input  done
    );

    modport slave (
        input  register_value,
        input  decimal_two,
        input  decimal_one,
        input  start,
        output out,
        output done
    );
endinterface

// File: rtl/relprime_top_level.sv
// rtl/relprime_top_level.sv - smallest m >= 2 with gcd(n, m) == 1, multicycle FSM
//   CLK : system clock, all state changes on posedge
//   RST : synchronous active-high reset, priority over start
//   bus : relprime_top_level_if slave (operands, start, out, done)
module relprime_top_level #(
    parameter int W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    relprime_top_level_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GCD,
        CHECK,
        NEXT,
        DONE
    } state_t;

    state_t       state, state_nx;
    logic [W-1:0] n_q, n_nx;
    logic [W-1:0] m_q, m_nx;
    logic [W-1:0] one_q, one_nx;
    logic [W-1:0] a_q, a_nx;
    logic [W-1:0] b_q, b_nx;
    logic [W-1:0] out_q, out_nx;
    logic         done_q, done_nx;
    logic [W-1:0] m_inc;

    assign m_inc    = m_q + one_q;
    assign bus.out  = out_q;
    assign bus.done = done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            n_q    <= '0;
            m_q    <= '0;
            one_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            n_q    <= n_nx;
            m_q    <= m_nx;
            one_q  <= one_nx;
            a_q    <= a_nx;
            b_q    <= b_nx;
            out_q  <= out_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        n_nx     = n_q;
        m_nx     = m_q;
        one_nx   = one_q;
        a_nx     = a_q;
        b_nx     = b_q;
        out_nx   = out_q;
        done_nx  = done_q;

        unique case (state)
            IDLE: begin
            end
            LOAD: begin
                // Operands are captured on every LOAD cycle, so a one-cycle
                // start pulse still seeds the search from the live inputs.
                n_nx    = bus.register_value;
                m_nx    = bus.decimal_two;
                one_nx  = bus.decimal_one;
                done_nx = 1'b0;
                if (!bus.start) begin
                    a_nx     = bus.register_value;
                    b_nx     = bus.decimal_two;
                    state_nx = GCD;
                end
            end
            GCD: begin
                if (b_q == '0) begin
                    state_nx = CHECK;
                end else if (a_q >= b_q) begin
                    a_nx = a_q - b_q;
                end else begin
                    a_nx = b_q;
                    b_nx = a_q;
                end
            end
            CHECK: begin
                if (a_q == one_q) begin
                    out_nx   = m_q;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = NEXT;
                end
            end
            NEXT: begin
                m_nx = m_inc;
                // Candidate wrapped to zero: every m was tried, report none.
                if (m_inc == '0) begin
                    out_nx   = '0;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else begin
                    a_nx     = n_q;
                    b_nx     = m_inc;
                    state_nx = GCD;
                end
            end
            DONE: begin
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // start aborts whatever is in flight and restarts from LOAD.
        if (bus.start) begin
            state_nx = LOAD;
            done_nx  = 1'b0;
        end
    end
endmodule

// File: tb/tb_relprime_top_level.sv
// tb/tb_relprime_top_level.sv - table-driven scoreboard bench for relprime_top_level
module tb_relprime_top_level;
    logic CLK;
    logic RST;

    relprime_top_level_if #(.W(16)) bus16 ();
    relprime_top_level_if #(.W(8))  bus8 ();

    relprime_top_level #(.W(16)) dut16 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus16.slave)
    );

    relprime_top_level #(.W(8)) dut8 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus8.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          narrow;
        logic [15:0] n;
        logic [15:0] exp;
    } vec_t;

    int          total;
    int          bad;
    logic [15:0] exp_q[$];
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_start(input bit narrow, input logic [15:0] n);
        @(negedge CLK);
        if (narrow) begin
            bus8.register_value = n[7:0];
            bus8.start          = 1'b1;
        end else begin
            bus16.register_value = n;
            bus16.start          = 1'b1;
        end
        repeat (2) @(negedge CLK);
        bus8.start  = 1'b0;
        bus16.start = 1'b0;
    endtask

    task automatic run_case(input bit narrow, input logic [15:0] n, input logic [15:0] exp);
        int          cyc;
        logic        dn;
        logic [15:0] got;
        logic [15:0] want;
        drive_start(narrow, n);
        exp_q.push_back(exp);
        dn = narrow ? bus8.done : bus16.done;
        check($sformatf("done_clear n=%0d", n), {31'd0, dn}, 32'd0);
        cyc = 0;
        dn  = 1'b0;
        got = '0;
        while (!dn && cyc < 20000) begin
            @(negedge CLK);
            cyc++;
            dn  = narrow ? bus8.done : bus16.done;
            got = narrow ? {8'h00, bus8.out} : bus16.out;
        end
        want = exp_q.pop_front();
        if (!dn) begin
            total++;
            bad++;
            $display("FAIL timeout n=%0d: done still 0 after %0d cycles, required 1", n, cyc);
        end else begin
            check($sformatf("out n=%0d w=%0d", n, narrow ? 8 : 16), {16'd0, got}, {16'd0, want});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        bus16.register_value = '0;
        bus16.decimal_two    = 16'd2;
        bus16.decimal_one    = 16'd1;
        bus16.start          = 1'b0;
        bus8.register_value  = '0;
        bus8.decimal_two     = 8'd2;
        bus8.decimal_one     = 8'd1;
        bus8.start           = 1'b0;

        vecs.push_back('{1'b0, 16'd5432, 16'd3});
        vecs.push_back('{1'b0, 16'd1,    16'd2});
        vecs.push_back('{1'b0, 16'd30,   16'd7});
        vecs.push_back('{1'b0, 16'd2,    16'd3});
        vecs.push_back('{1'b0, 16'd6,    16'd5});
        vecs.push_back('{1'b0, 16'd15,   16'd2});
        vecs.push_back('{1'b0, 16'd2310, 16'd13});
        vecs.push_back('{1'b1, 16'd0,    16'd0});
        vecs.push_back('{1'b1, 16'd1,    16'd2});
        vecs.push_back('{1'b1, 16'd210,  16'd11});
        vecs.push_back('{1'b1, 16'd255,  16'd2});

        repeat (2) @(negedge CLK);
        check("rst out16",  {16'd0, bus16.out}, 32'd0);
        check("rst done16", {31'd0, bus16.done}, 32'd0);
        check("rst out8",   {24'd0, bus8.out}, 32'd0);
        check("rst done8",  {31'd0, bus8.done}, 32'd0);
        RST = 1'b0;

        foreach (vecs[i]) begin
            run_case(vecs[i].narrow, vecs[i].n, vecs[i].exp);
        end

        // Result holds in DONE while the operand input changes.
        bus16.register_value = 16'd1234;
        repeat (5) @(negedge CLK);
        check("hold done", {31'd0, bus16.done}, 32'd1);
        check("hold out",  {16'd0, bus16.out}, 32'd13);

        // start mid-computation aborts and reloads.
        drive_start(1'b0, 16'd5432);
        repeat (100) @(negedge CLK);
        check("abort busy done", {31'd0, bus16.done}, 32'd0);
        run_case(1'b0, 16'd9, 16'd2);

        // RST mid-computation clears out and done on the next cycle.
        drive_start(1'b0, 16'd5432);
        repeat (50) @(negedge CLK);
        check("midrun out before rst", {16'd0, bus16.out}, 32'd2);
        RST = 1'b1;
        @(negedge CLK);
        check("midrun rst out",  {16'd0, bus16.out}, 32'd0);
        check("midrun rst done", {31'd0, bus16.done}, 32'd0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("idle after rst done", {31'd0, bus16.done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
